// File: rtl/lut_config_loader.sv
// Configuration frame loader for the logic-block array.
// Assembles per-block 16-bit LUT tables and output-select bits from a byte stream
// into shadow registers, verifies an XOR checksum, then commits all blocks at once.
// Optional feature: define LUT_CFG_LOCK_EN to add a sticky lock set by the first
// successful commit; once locked every byte is accepted and discarded until reset.
module lut_config_loader #(
   parameter int unsigned NUM_LB   = 4,
   parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             cfg_data,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   output logic [16*NUM_LB-1:0]   lb_config,
   output logic [NUM_LB-1:0]      lb_sel,
   output logic                   cfg_busy,
   output logic                   cfg_done,
   output logic                   cfg_error
);

   // Block index must be able to reach NUM_LB, which marks the checksum byte.
   localparam int unsigned BlkW = $clog2(NUM_LB + 1);

   typedef enum logic [1:0] {StIdle, StLoad, StCheck} state_e;

   state_e                    state_q, state_d;
   logic [BlkW-1:0]           blk_q, blk_d;
   logic [1:0]                fld_q, fld_d;
   logic [7:0]                csum_q, csum_d;
   logic [7:0]                chk_q, chk_d;
   logic [NUM_LB-1:0][15:0]   shd_cfg_q, shd_cfg_d;
   logic [NUM_LB-1:0]         shd_sel_q, shd_sel_d;
   logic [16*NUM_LB-1:0]      cfg_q, cfg_d;
   logic [NUM_LB-1:0]         sel_q, sel_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;
   logic                      accept;
   logic                      locked;

`ifdef LUT_CFG_LOCK_EN
   logic                      lock_q, lock_d;
   assign locked = lock_q;
`else
   assign locked = 1'b0;
`endif

   // Ready follows the registered state; forced low while reset is held.
   assign cfg_ready = reset && (state_q != StCheck);
   assign accept    = cfg_valid && cfg_ready;
   assign cfg_busy  = (state_q != StIdle);
   assign cfg_done  = done_q;
   assign cfg_error = err_q;
   assign lb_config = cfg_q;
   assign lb_sel    = sel_q;

   // Next-state: header detect, payload capture into shadow, checksum verify and commit.
   always_comb begin
      state_d   = state_q;
      blk_d     = blk_q;
      fld_d     = fld_q;
      csum_d    = csum_q;
      chk_d     = chk_q;
      shd_cfg_d = shd_cfg_q;
      shd_sel_d = shd_sel_q;
      cfg_d     = cfg_q;
      sel_d     = sel_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
`ifdef LUT_CFG_LOCK_EN
      lock_d    = lock_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept && !locked && (cfg_data == HDR_BYTE)) begin
               state_d = StLoad;
               blk_d   = '0;
               fld_d   = '0;
               csum_d  = '0;
            end
         end
         StLoad: begin
            if (accept) begin
               if (blk_q == BlkW'(NUM_LB)) begin
                  chk_d   = cfg_data;
                  state_d = StCheck;
               end else begin
                  csum_d = csum_q ^ cfg_data;
                  for (int unsigned i = 0; i < NUM_LB; i++) begin
                     if (blk_q == BlkW'(i)) begin
                        case (fld_q)
                           2'd0:    shd_cfg_d[i][7:0]  = cfg_data;
                           2'd1:    shd_cfg_d[i][15:8] = cfg_data;
                           default: shd_sel_d[i]       = cfg_data[0];
                        endcase
                     end
                  end
                  if (fld_q == 2'd2) begin
                     fld_d = 2'd0;
                     blk_d = blk_q + 1'b1;
                  end else begin
                     fld_d = fld_q + 2'd1;
                  end
               end
            end
         end
         StCheck: begin
            state_d = StIdle;
            if (csum_q == chk_q) begin
               cfg_d  = shd_cfg_q;
               sel_d  = shd_sel_q;
               done_d = 1'b1;
`ifdef LUT_CFG_LOCK_EN
               lock_d = 1'b1;
`endif
            end else begin
               err_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         blk_q     <= '0;
         fld_q     <= '0;
         csum_q    <= '0;
         chk_q     <= '0;
         shd_cfg_q <= '0;
         shd_sel_q <= '0;
         cfg_q     <= '0;
         sel_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef LUT_CFG_LOCK_EN
         lock_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         blk_q     <= blk_d;
         fld_q     <= fld_d;
         csum_q    <= csum_d;
         chk_q     <= chk_d;
         shd_cfg_q <= shd_cfg_d;
         shd_sel_q <= shd_sel_d;
         cfg_q     <= cfg_d;
         sel_q     <= sel_d;
         done_q    <= done_d;
         err_q     <= err_d;
`ifdef LUT_CFG_LOCK_EN
         lock_q    <= lock_d;
`endif
      end
   end

endmodule
